// File: rtl/psum_pkg.sv
// Shared types and helpers for the partial-sum accumulation buffer.
// Optional ReLU-on-drain is enabled by defining PSUM_ACC_BUFFER_RELU_EN.
package psum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int laneLsb(input int lane, input int bw);
        return lane * bw;
    endfunction

    function automatic longint satMax(input int bw);
        return (longint'(1) <<< (bw - 1)) - longint'(1);
    endfunction

    function automatic longint satMin(input int bw);
        return -(longint'(1) <<< (bw - 1));
    endfunction

    // Operands are sign-extended to 64 bits, so the sum itself cannot wrap for bw <= 62.
    function automatic longint sat_add(input longint a, input longint b, input int bw);
        longint sum;
        sum = a + b;
        if (sum > satMax(bw)) return satMax(bw);
        if (sum < satMin(bw)) return satMin(bw);
        return sum;
    endfunction

endpackage

// File: rtl/psum_lane_sat_add.sv
// Single-lane signed add with saturation to BW bits.
// Used by psum_acc_buffer (optional PSUM_ACC_BUFFER_RELU_EN does not affect this block).
module psum_lane_sat_add
    import psum_pkg::*;
#(
    parameter int BW = 16
) (
    input  logic [BW-1:0] a,
    input  logic [BW-1:0] b,
    output logic [BW-1:0] sum
);

    always_comb begin
        sum = BW'(sat_add(longint'($signed(a)), longint'($signed(b)), BW));
    end

endmodule

// File: rtl/psum_acc_buffer.sv
// Partial-sum accumulate/overwrite buffer with saturating RMW and a wrapping drain stream.
// Define PSUM_ACC_BUFFER_RELU_EN to add a per-drain relu_en input that zeroes negative lanes on output.
module psum_acc_buffer
    import psum_pkg::*;
#(
    parameter  int COL     = 8,
    parameter  int PSUM_BW = 16,
    parameter  int DEPTH   = 2048,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      in_addr,
    input  logic                   in_acc,
    input  logic [PSUM_BW*COL-1:0] in_data,
    input  logic                   drain_start,
    input  logic [ADDR_W-1:0]      drain_base,
    input  logic [ADDR_W:0]        drain_len,
    input  logic                   drain_clear,
`ifdef PSUM_ACC_BUFFER_RELU_EN
    input  logic                   relu_en,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PSUM_BW*COL-1:0] out_data,
    output logic                   drain_done,
    output logic                   busy
);

    localparam int W = PSUM_BW * COL;
    localparam logic [ADDR_W:0]   ONE_CNT  = 1;
    localparam logic [ADDR_W-1:0] ONE_ADDR = 1;

    state_t            state;
    logic [W-1:0]      mem [DEPTH];

    logic              accept;
    logic [W-1:0]      rdOld;
    logic              s1Valid;
    logic              s1Acc;
    logic [ADDR_W-1:0] s1Addr;
    logic [W-1:0]      s1Data;
    logic [W-1:0]      s1Old;
    logic [W-1:0]      addA;
    logic [W-1:0]      s1Result;

    logic [ADDR_W:0]   lenLat;
    logic              clrLat;
`ifdef PSUM_ACC_BUFFER_RELU_EN
    logic              reluLat;
`endif
    logic [ADDR_W-1:0] rdAddr;
    logic [ADDR_W:0]   issueCnt;
    logic [ADDR_W:0]   acceptCnt;
    logic              issue;
    logic              outAccept;
    logic              lastAccept;
    logic              outValid;
    logic [W-1:0]      outData;
    logic [W-1:0]      rdWord;
    logic [W-1:0]      outWord;

    assign in_ready = (state == IDLE) && !reset;
    assign accept   = in_valid && in_ready;

    // A result still in stage 1 has not reached the array yet; forward it.
    assign rdOld = (s1Valid && (s1Addr == in_addr)) ? s1Result : mem[in_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1Valid <= 1'b0;
            s1Acc   <= 1'b0;
            s1Addr  <= '0;
            s1Data  <= '0;
            s1Old   <= '0;
        end else begin
            s1Valid <= accept;
            if (accept) begin
                s1Addr <= in_addr;
                s1Acc  <= in_acc;
                s1Data <= in_data;
                s1Old  <= rdOld;
            end
        end
    end

    assign addA = s1Acc ? s1Old : '0;

    for (genvar g = 0; g < COL; g++) begin : gLane
        localparam int LSB = laneLsb(g, PSUM_BW);
        psum_lane_sat_add #(.BW(PSUM_BW)) uSat (
            .a   (addA[LSB +: PSUM_BW]),
            .b   (s1Data[LSB +: PSUM_BW]),
            .sum (s1Result[LSB +: PSUM_BW])
        );
    end

    // The output register doubles as the skid slot: a read is issued only when it can be loaded.
    assign issue      = (state == DRAIN) && (issueCnt != lenLat) && (!outValid || out_ready);
    assign outAccept  = outValid && out_ready;
    assign lastAccept = outAccept && (acceptCnt == (lenLat - ONE_CNT));
    assign rdWord     = mem[rdAddr];

    always_comb begin
        outWord = rdWord;
`ifdef PSUM_ACC_BUFFER_RELU_EN
        if (reluLat) begin
            for (int unsigned i = 0; i < COL; i++) begin
                if (rdWord[i*PSUM_BW + PSUM_BW - 1]) outWord[i*PSUM_BW +: PSUM_BW] = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (s1Valid) mem[s1Addr] <= s1Result;
        else if (issue && clrLat) mem[rdAddr] <= '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lenLat    <= '0;
            clrLat    <= 1'b0;
`ifdef PSUM_ACC_BUFFER_RELU_EN
            reluLat   <= 1'b0;
`endif
            rdAddr    <= '0;
            issueCnt  <= '0;
            acceptCnt <= '0;
            outValid  <= 1'b0;
            outData   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (drain_start) begin
                        state     <= FLUSH;
                        lenLat    <= drain_len;
                        clrLat    <= drain_clear;
`ifdef PSUM_ACC_BUFFER_RELU_EN
                        reluLat   <= relu_en;
`endif
                        rdAddr    <= drain_base;
                        issueCnt  <= '0;
                        acceptCnt <= '0;
                    end
                end
                // At most one write is still in stage 1 here and it lands at the end of this cycle.
                FLUSH: state <= (lenLat == '0) ? DONE : DRAIN;
                DRAIN: begin
                    if (issue) begin
                        rdAddr   <= rdAddr + ONE_ADDR;
                        issueCnt <= issueCnt + ONE_CNT;
                        outData  <= outWord;
                        outValid <= 1'b1;
                    end else if (outAccept) begin
                        outValid <= 1'b0;
                    end
                    if (outAccept) acceptCnt <= acceptCnt + ONE_CNT;
                    if (lastAccept) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid  = outValid;
    assign out_data   = outData;
    assign drain_done = (state == DONE);
    assign busy       = (state != IDLE) || s1Valid;

endmodule

// File: tb/tb_psum_acc_buffer.sv
// Directed self-checking bench for psum_acc_buffer (COL=8, PSUM_BW=16, DEPTH=16).
// Default build: PSUM_ACC_BUFFER_RELU_EN undefined; relu_en is tied low when it is defined.
module tb_psum_acc_buffer;

    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int DEP = 16;
    localparam int W   = COL * BW;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_addr;
    logic         in_acc;
    logic [W-1:0] in_data;
    logic         drain_start;
    logic [3:0]   drain_base;
    logic [4:0]   drain_len;
    logic         drain_clear;
`ifdef PSUM_ACC_BUFFER_RELU_EN
    logic         relu_en = 1'b0;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         drain_done;
    logic         busy;

    int testCnt = 0;
    int failCnt = 0;

    logic [W-1:0] gotWords [16];
    int gotCnt;
    int doneCnt;
    int validCnt;

    psum_acc_buffer #(.COL(COL), .PSUM_BW(BW), .DEPTH(DEP)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_acc      (in_acc),
        .in_data     (in_data),
        .drain_start (drain_start),
        .drain_base  (drain_base),
        .drain_len   (drain_len),
        .drain_clear (drain_clear),
`ifdef PSUM_ACC_BUFFER_RELU_EN
        .relu_en     (relu_en),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .drain_done  (drain_done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic checkEq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        testCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rep(input int v);
        logic [W-1:0] r;
        logic [BW-1:0] t;
        t = v[BW-1:0];
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = t;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic writeReq(input int addr, input logic acc, input int val);
        in_valid = 1'b1;
        in_addr  = 4'(addr);
        in_acc   = acc;
        in_data  = rep(val);
        step();
        in_valid = 1'b0;
    endtask

    // stallMask bit k drops out_ready on the k-th cycle that out_valid is high.
    task automatic runDrain(input int base, input int len, input logic clr, input logic [3:0] stallMask);
        int vIdx;
        logic prevStall;
        logic [W-1:0] prevData;
        gotCnt = 0; doneCnt = 0; validCnt = 0;
        vIdx = 0; prevStall = 1'b0; prevData = '0;
        drain_base  = 4'(base);
        drain_len   = 5'(len);
        drain_clear = clr;
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (out_valid) begin
                out_ready = (vIdx < 4) ? !stallMask[vIdx[1:0]] : 1'b1;
                if (prevStall) checkEq("hold", out_data, prevData);
                if (out_ready && gotCnt < 16) begin
                    gotWords[gotCnt] = out_data;
                    gotCnt++;
                end
                prevStall = !out_ready;
                prevData  = out_data;
                vIdx++;
                validCnt++;
            end else begin
                out_ready = 1'b1;
                prevStall = 1'b0;
            end
            if (drain_done) doneCnt++;
            step();
        end
        out_ready = 1'b1;
    endtask

    initial begin
        int beats;
        reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_acc = 1'b0; in_data = '0;
        drain_start = 1'b0; drain_base = '0; drain_len = '0; drain_clear = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkEq("rst_in_ready",   W'(in_ready),   W'(0));
        checkEq("rst_out_valid",  W'(out_valid),  W'(0));
        checkEq("rst_out_data",   out_data,       '0);
        checkEq("rst_drain_done", W'(drain_done), W'(0));
        checkEq("rst_busy",       W'(busy),       W'(0));
        reset = 1'b0;
        #1;
        checkEq("in_ready_idle", W'(in_ready), W'(1));
        step();

        // overwrite then accumulate
        writeReq(5, 1'b0, 10);
        writeReq(5, 1'b1, 7);
        checkEq("busy_write", W'(busy), W'(1));
        runDrain(5, 1, 1'b0, 4'b0000);
        checkEq("acc_cnt",  W'(gotCnt), W'(1));
        checkEq("acc_word", gotWords[0], rep(17));
        checkEq("acc_done", W'(doneCnt), W'(1));

        // forwarding chain
        writeReq(9, 1'b0, 0);
        writeReq(9, 1'b1, 1);
        writeReq(9, 1'b1, 1);
        writeReq(9, 1'b1, 1);
        runDrain(9, 1, 1'b0, 4'b0000);
        checkEq("fwd_cnt",  W'(gotCnt), W'(1));
        checkEq("fwd_word", gotWords[0], rep(3));
        checkEq("fwd_done", W'(doneCnt), W'(1));

        // saturation both directions
        writeReq(2, 1'b0, 32000);
        writeReq(2, 1'b1, 1000);
        writeReq(3, 1'b0, -32000);
        writeReq(3, 1'b1, -1000);
        runDrain(2, 2, 1'b0, 4'b0000);
        checkEq("sat_cnt", W'(gotCnt), W'(2));
        checkEq("sat_pos", gotWords[0], rep(32767));
        checkEq("sat_neg", gotWords[1], rep(-32768));
        checkEq("sat_done", W'(doneCnt), W'(1));

        // wrap with backpressure 1,0,0,1
        writeReq(14, 1'b0, 14);
        writeReq(15, 1'b0, 15);
        writeReq(0,  1'b0, 100);
        writeReq(1,  1'b0, 101);
        runDrain(14, 4, 1'b0, 4'b0110);
        checkEq("wrap_cnt", W'(gotCnt), W'(4));
        checkEq("wrap_w0",  gotWords[0], rep(14));
        checkEq("wrap_w1",  gotWords[1], rep(15));
        checkEq("wrap_w2",  gotWords[2], rep(100));
        checkEq("wrap_w3",  gotWords[3], rep(101));
        checkEq("wrap_done", W'(doneCnt), W'(1));

        // drain with clear, then drain again
        runDrain(14, 4, 1'b1, 4'b0000);
        checkEq("clr_cnt", W'(gotCnt), W'(4));
        checkEq("clr_w0",  gotWords[0], rep(14));
        checkEq("clr_w3",  gotWords[3], rep(101));
        runDrain(14, 4, 1'b0, 4'b0000);
        checkEq("zero_cnt", W'(gotCnt), W'(4));
        for (int i = 0; i < 4; i++) checkEq("zero_word", gotWords[i], '0);

        // len = 0
        runDrain(0, 0, 1'b0, 4'b0000);
        checkEq("len0_valid", W'(validCnt), W'(0));
        checkEq("len0_done",  W'(doneCnt),  W'(1));

        // reset on the second drain beat
        drain_base = 4'd14; drain_len = 5'd4; drain_clear = 1'b0; drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        beats = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (out_valid) begin
                beats++;
                if (beats == 2) break;
            end
            step();
        end
        checkEq("mid_beats", W'(beats), W'(2));
        reset = 1'b1;
        #1;
        checkEq("mid_out_valid", W'(out_valid), W'(0));
        checkEq("mid_out_data",  out_data,      '0);
        checkEq("mid_busy",      W'(busy),      W'(0));
        checkEq("mid_in_ready",  W'(in_ready),  W'(0));
        step();
        reset = 1'b0;
        #1;
        checkEq("post_in_ready", W'(in_ready), W'(1));
        doneCnt = 0; validCnt = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (drain_done) doneCnt++;
            if (out_valid) validCnt++;
            step();
        end
        checkEq("post_done",  W'(doneCnt),  W'(0));
        checkEq("post_valid", W'(validCnt), W'(0));

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule

// File: doc/psum_acc_buffer.md
Name: psum_acc_buffer

Overview:
- Parametrised partial-sum accumulation buffer that replaces the fixed-size write-only psum SRAM path of the current core.
- Accepts one column-vector of partial sums per cycle from the corelet/array and performs read-modify-write accumulation (or overwrite) at a given address, with saturation.
- On request, drains a contiguous, wrapping address range to the SFP/output stage over a valid/ready stream.
- Serves both WS and OS dataflows; OS simply uses overwrite mode.

Parameters:
- COL, 8, number of output lanes (columns).
- PSUM_BW, 16, signed bits per lane.
- DEPTH, 2048, number of entries; power of two.
- ADDR_W, $clog2(DEPTH), address width (derived; not overridden).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  write/accumulate request.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_addr  in  ADDR_W  target entry.
- in_acc  in  1  1 = accumulate onto stored value; 0 = overwrite.
- in_data  in  PSUM_BW*COL  lane i at bits [i*PSUM_BW +: PSUM_BW], signed.
- drain_start  in  1  single-cycle drain request.
- drain_base  in  ADDR_W  first drain address.
- drain_len  in  ADDR_W+1  number of entries to drain, 0..DEPTH.
- drain_clear  in  1  zero each entry after it is read during the drain.
- out_valid  out  1  drain word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  PSUM_BW*COL  drained word.
- drain_done  out  1  one-cycle pulse after the last drain word is accepted.
- busy  out  1  high when the FSM is not in IDLE or the pipeline is non-empty.

Behaviour:
- Reset values: in_ready=0 during reset, out_valid=0, out_data=0, drain_done=0, busy=0; pipeline valid bits cleared; FSM goes to IDLE. Storage array is not reset; contents after reset are unspecified and must not be checked.
- FSM states: IDLE, FLUSH, DRAIN, DONE.
- in_ready=1 only in IDLE (and not in reset).
- Write pipeline, 2 stages:
  - Cycle T: request accepted; stored entry read.
  - Cycle T+1: per lane, result = sat(in_acc ? old + in_data : in_data); written at the end of T+1.
  - Readable by any request accepted at T+1 or later.
- Forwarding: if the stage-1 address equals the address of a request accepted in the same cycle, the stage-1 result replaces the stored value. Back-to-back accumulates to one address must chain correctly.
- Saturation per lane, signed PSUM_BW: overflow clamps to 2^(PSUM_BW-1)-1; underflow clamps to -2^(PSUM_BW-1).
- IDLE → FLUSH on drain_start. Base, len and clear are latched at that cycle. A write accepted in the same cycle is included in the drain.
- FLUSH → DRAIN once the stage-1 write has retired (0 or 1 cycle).
- DRAIN:
  - Reads addresses base, base+1, … modulo DEPTH (wraps DEPTH-1 → 0).
  - out_valid rises the cycle after the first read.
  - One-word skid register gives 1 word/cycle while out_ready=1.
  - out_data is held stable while out_valid && !out_ready.
  - With drain_clear latched, an entry is written to 0 in the cycle its read is issued.
- DRAIN → DONE when the len-th word is accepted. DONE pulses drain_done and returns to IDLE.
- drain_len=0: FLUSH → DONE directly; no out_valid is produced.
- drain_len=DEPTH: every entry is drained exactly once.
- drain_start outside IDLE is ignored.
- Reset mid-drain: out_valid drops asynchronously, no drain_done is produced, FSM returns to IDLE.

Optional Feature:
- Macro PSUM_ACC_BUFFER_RELU_EN.
- Defined: a per-drain relu_en input is added and latched with drain_start. When set, drained lanes with a negative value output 0. Storage is unaffected.
- Undefined: no port is added; drained data is raw.

Decomposition:
- Shared package (psum_pkg) holds the FSM state enum, the lane slice helper, the signed saturation constants, and the sat_add function.
- One sub-module, psum_lane_sat_add: a single-lane PSUM_BW signed add with saturation, instantiated COL times.
- Storage is an inferred register array inside the top module.

Test Plan:
- Overwrite then accumulate: write addr 5 = all lanes 10 (acc=0), then acc lanes +7 → drain base 5, len 1 outputs all lanes 17 and one drain_done pulse.
- Forwarding: 3 back-to-back accumulates of +1 to addr 9, starting from 0 → drained value 3 in every lane.
- Saturation (PSUM_BW=16):
  - 32000 + 1000 → 32767.
  - -32000 + (-1000) → -32768.
- Wrap and backpressure, DEPTH=16:
  - Drain base 14, len 4 yields addresses 14, 15, 0, 1 in order.
  - out_ready toggled 1,0,0,1 holds out_data stable while stalled.
- drain_clear and len edge cases:
  - Drain with clear, then drain again → all zeros.
  - len=0 → drain_done after FLUSH with no out_valid.
- Reset asserted on the 2nd drain beat → out_valid=0 immediately; in_ready=1 the first cycle after reset deasserts.
